// File: rtl/kyber_encrypt.sv
// rtl/kyber_encrypt.sv - serial-MAC Kyber-style encryption core; optional output compression via KYBER_ENC_COMPRESS_EN
module kyber_encrypt #(
    parameter int Q = 17,
    parameter int N = 4,
    parameter int K = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enc_start,
    input  logic signed [K*K-1:0][N-1:0][31:0]  pk_a,
    input  logic signed [K-1:0][N-1:0][31:0]    pk_t,
    input  logic signed [K-1:0][N-1:0][31:0]    r,
    input  logic signed [K-1:0][N-1:0][31:0]    e1,
    input  logic signed [N-1:0][31:0]           e2,
    input  logic [N-1:0]                        msg,
    output logic signed [K-1:0][N-1:0][31:0]    u,
    output logic signed [N-1:0][31:0]           v,
    output logic                                enc_busy,
    output logic                                enc_done
);

    // Term counter splits into {polynomial j, product index m}; coefficient
    // counter splits into {output polynomial (u0, u1, v), coefficient k}.
    localparam int TERMS = K * N;
    localparam int NCOEF = (K + 1) * N;
    localparam int TW    = $clog2(TERMS);
    localparam int CW    = $clog2(NCOEF);
    localparam int MW    = $clog2(N);

    localparam logic [TW-1:0]    LAST_TERM = TW'(TERMS - 1);
    localparam logic [CW-1:0]    LAST_COEF = CW'(NCOEF - 1);
    localparam logic [CW-MW-1:0] V_SEL     = (CW - MW)'(K);

    localparam logic signed [63:0] Q64       = 64'(Q);
    localparam logic signed [63:0] MSG_SCALE = 64'((Q + 1) / 2);

`ifdef KYBER_ENC_COMPRESS_EN
    // Rounded compression: floor((2^(d+1)*x + q) / 2q) mod 2^d, d=3 for u, d=2 for v
    localparam logic signed [63:0] SCALE_U = 64'sd16;
    localparam logic signed [63:0] MOD_U   = 64'sd8;
    localparam logic signed [63:0] SCALE_V = 64'sd8;
    localparam logic signed [63:0] MOD_V   = 64'sd4;
`endif

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Operand snapshot taken on the accepted start
    logic signed [K*K-1:0][N-1:0][31:0] a_q;
    logic signed [K-1:0][N-1:0][31:0]   t_q;
    logic signed [K-1:0][N-1:0][31:0]   r_q;
    logic signed [K-1:0][N-1:0][31:0]   e1_q;
    logic signed [N-1:0][31:0]          e2_q;
    logic [N-1:0]                       msg_q;

    logic [TW-1:0]      term_cnt;
    logic [CW-1:0]      coef_cnt;
    logic signed [63:0] acc;

    logic [TW-MW-1:0]   j_idx;
    logic [MW-1:0]      m_idx;
    logic [MW-1:0]      k_idx;
    logic [MW-1:0]      b_idx;
    logic [CW-MW-1:0]   poly_sel;
    logic               is_v;
    logic               wrap;
    logic               last_term;
    logic               last_coef;

    logic signed [31:0] a_sel;
    logic signed [31:0] b_sel;
    logic signed [31:0] err_sel;
    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;
    logic signed [63:0] prod;
    logic signed [63:0] term_sum;
    logic signed [63:0] msg_add;
    logic signed [63:0] final_sum;
    logic signed [63:0] red64;
`ifdef KYBER_ENC_COMPRESS_EN
    logic signed [63:0] comp;
`endif
    logic signed [31:0] out_val;

    assign j_idx     = term_cnt[TW-1:MW];
    assign m_idx     = term_cnt[MW-1:0];
    assign poly_sel  = coef_cnt[CW-1:MW];
    assign k_idx     = coef_cnt[MW-1:0];
    // Partner index wraps mod N; products with m > k land on x^(k+N) and flip sign
    assign b_idx     = k_idx - m_idx;
    assign wrap      = (m_idx > k_idx);
    assign is_v      = (poly_sel == V_SEL);
    assign last_term = (term_cnt == LAST_TERM);
    assign last_coef = (coef_cnt == LAST_COEF);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_next = state;
        enc_busy   = 1'b0;
        enc_done   = 1'b0;
        case (state)
            IDLE: begin
                if (enc_start) begin
                    state_next = MAC;
                end
            end
            MAC: begin
                enc_busy = 1'b1;
                if (last_term && last_coef) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                enc_busy   = 1'b1;
                enc_done   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand selection, signed MAC, final reduction and optional compression
    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        err_sel = '0;
        msg_add = '0;
        if (is_v) begin
            a_sel   = t_q[j_idx][m_idx];
            err_sel = e2_q[k_idx];
            if (msg_q[k_idx]) begin
                msg_add = MSG_SCALE;
            end
        end else begin
            a_sel   = a_q[{j_idx, poly_sel[0]}][m_idx];
            err_sel = e1_q[poly_sel[0]][k_idx];
        end
        b_sel = r_q[j_idx][b_idx];

        a_ext     = 64'(a_sel);
        b_ext     = 64'(b_sel);
        prod      = a_ext * b_ext;
        term_sum  = wrap ? (acc - prod) : (acc + prod);
        final_sum = term_sum + 64'(err_sel) + msg_add;

        red64 = final_sum % Q64;
        if (red64 < 0) begin
            red64 = red64 + Q64;
        end

`ifdef KYBER_ENC_COMPRESS_EN
        if (is_v) begin
            comp = (((red64 * SCALE_V) + Q64) / (Q64 * 64'sd2)) % MOD_V;
        end else begin
            comp = (((red64 * SCALE_U) + Q64) / (Q64 * 64'sd2)) % MOD_U;
        end
        out_val = 32'(comp);
`else
        out_val = 32'(red64);
`endif
    end

    // Capture, per-term accumulation and coefficient write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            t_q      <= '0;
            r_q      <= '0;
            e1_q     <= '0;
            e2_q     <= '0;
            msg_q    <= '0;
            term_cnt <= '0;
            coef_cnt <= '0;
            acc      <= '0;
            u        <= '0;
            v        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enc_start) begin
                        a_q      <= pk_a;
                        t_q      <= pk_t;
                        r_q      <= r;
                        e1_q     <= e1;
                        e2_q     <= e2;
                        msg_q    <= msg;
                        term_cnt <= '0;
                        coef_cnt <= '0;
                        acc      <= '0;
                        u        <= '0;
                        v        <= '0;
                    end
                end
                MAC: begin
                    if (last_term) begin
                        if (is_v) begin
                            v[k_idx] <= out_val;
                        end else begin
                            u[poly_sel[0]][k_idx] <= out_val;
                        end
                        acc      <= '0;
                        term_cnt <= '0;
                        coef_cnt <= last_coef ? '0 : coef_cnt + 1'b1;
                    end else begin
                        acc      <= term_sum;
                        term_cnt <= term_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kyber_encrypt.sv
// tb/tb_kyber_encrypt.sv - self-checking bench for kyber_encrypt against a polynomial-level reference model
module tb_kyber_encrypt;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        enc_start;
    logic signed [3:0][3:0][31:0] pk_a;
    logic signed [1:0][3:0][31:0] pk_t;
    logic signed [1:0][3:0][31:0] r;
    logic signed [1:0][3:0][31:0] e1;
    logic signed [3:0][31:0]      e2;
    logic [3:0]                   msg;
    logic signed [1:0][3:0][31:0] u;
    logic signed [3:0][31:0]      v;
    logic                         enc_busy;
    logic                         enc_done;

    always #5 clk = ~clk;

    kyber_encrypt dut (
        .clk       (clk),
        .rst       (rst),
        .enc_start (enc_start),
        .pk_a      (pk_a),
        .pk_t      (pk_t),
        .r         (r),
        .e1        (e1),
        .e2        (e2),
        .msg       (msg),
        .u         (u),
        .v         (v),
        .enc_busy  (enc_busy),
        .enc_done  (enc_done)
    );

    int     n_assert = 0;
    int     n_fail   = 0;
    longint exp_u [2][4];
    longint exp_v [4];
    int     done_cyc;
    int     done_cnt;
    int     busy_err;

    task automatic chk(input string tag, input longint observed, input longint expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic logic signed [31:0] rnd();
        logic signed [31:0] x;
        x = $signed($urandom);
        if (x[0]) return x >>> 2;
        return $signed($urandom_range(0, 40)) - 32'sd20;
    endfunction

    function automatic longint compress(input longint m, input bit is_v);
        if (is_v) return ((8 * m + 17) / 34) % 4;
        return ((16 * m + 17) / 34) % 8;
    endfunction

    function automatic longint fin(input longint x, input bit is_v);
        longint m;
        m = x % 17;
        if (m < 0) m = m + 17;
`ifdef KYBER_ENC_COMPRESS_EN
        m = compress(m, is_v);
`endif
        return m;
    endfunction

    task automatic zero_inputs();
        pk_a = '0;
        pk_t = '0;
        r    = '0;
        e1   = '0;
        e2   = '0;
        msg  = '0;
    endtask

    task automatic rand_inputs();
        for (int p = 0; p < 4; p++)
            for (int c = 0; c < 4; c++) pk_a[p][c] = rnd();
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 4; c++) begin
                pk_t[p][c] = rnd();
                r[p][c]    = rnd();
                e1[p][c]   = rnd();
            end
        for (int c = 0; c < 4; c++) e2[c] = rnd();
        msg = 4'($urandom);
    endtask

    // Reference: negacyclic polynomial products mod x^4+1, then mod-17 reduction
    task automatic model();
        longint acc [4];
        longint p;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) acc[k] = 0;
            for (int j = 0; j < 2; j++)
                for (int x = 0; x < 4; x++)
                    for (int y = 0; y < 4; y++) begin
                        p = longint'($signed(pk_a[2*j+i][x])) * longint'($signed(r[j][y]));
                        if (x + y < 4) acc[x+y] += p;
                        else           acc[x+y-4] -= p;
                    end
            for (int k = 0; k < 4; k++)
                exp_u[i][k] = fin(acc[k] + longint'($signed(e1[i][k])), 1'b0);
        end
        for (int k = 0; k < 4; k++) acc[k] = 0;
        for (int j = 0; j < 2; j++)
            for (int x = 0; x < 4; x++)
                for (int y = 0; y < 4; y++) begin
                    p = longint'($signed(pk_t[j][x])) * longint'($signed(r[j][y]));
                    if (x + y < 4) acc[x+y] += p;
                    else           acc[x+y-4] -= p;
                end
        for (int k = 0; k < 4; k++)
            exp_v[k] = fin(acc[k] + longint'($signed(e2[k])) + (msg[k] ? 9 : 0), 1'b1);
    endtask

    task automatic model_zero();
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++) exp_u[i][k] = 0;
        for (int k = 0; k < 4; k++) exp_v[k] = 0;
    endtask

    task automatic check_outputs(input string name);
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++)
                chk($sformatf("%s u[%0d][%0d]", name, i, k), longint'($signed(u[i][k])), exp_u[i][k]);
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s v[%0d]", name, k), longint'($signed(v[k])), exp_v[k]);
    endtask

    // Edge 0 accepts the start; loop index is the cycle number following that edge
    task automatic run_op(input int pulse_a, input int pulse_b, input int rst_at, input bit scramble);
        bit busy_exp;
        done_cyc = -1;
        done_cnt = 0;
        busy_err = 0;
        @(negedge clk);
        enc_start = 1'b1;
        @(posedge clk);
        #1;
        enc_start = 1'b0;
        for (int cyc = 1; cyc <= 110; cyc++) begin
            busy_exp = (rst_at >= 0) ? (cyc <= rst_at) : (cyc <= 97);
            if (enc_busy !== busy_exp) busy_err++;
            if (enc_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (scramble) rand_inputs();
            enc_start = (cyc == pulse_a) || (cyc == pulse_b);
            rst       = (cyc == rst_at);
            @(posedge clk);
            #1;
        end
        enc_start = 1'b0;
        rst       = 1'b0;
    endtask

    initial begin
        // Reset with random inputs and a competing start
        rst       = 1'b1;
        enc_start = 1'b1;
        rand_inputs();
        repeat (2) @(posedge clk);
        #1;
        model_zero();
        check_outputs("reset");
        chk("reset enc_busy", longint'(enc_busy), 0);
        chk("reset enc_done", longint'(enc_done), 0);
        @(negedge clk);
        rst       = 1'b0;
        enc_start = 1'b0;
        @(posedge clk);
        #1;
        chk("post-reset idle busy", longint'(enc_busy), 0);

        // Message only
        zero_inputs();
        msg = 4'b1011;
        model();
        run_op(-1, -1, -1, 1'b0);
        chk("msg done_cycle", done_cyc, 97);
        chk("msg done_count", done_cnt, 1);
        chk("msg busy_profile", busy_err, 0);
        check_outputs("msg");

        // Negacyclic wrap: x^3 * x = -1
        zero_inputs();
        pk_a[0][3] = 32'sd1;
        r[0][1]    = 32'sd1;
        model();
        run_op(-1, -1, -1, 1'b0);
        chk("wrap done_cycle", done_cyc, 97);
        check_outputs("wrap");

        // Negative error terms
        zero_inputs();
        e1[0][0] = -32'sd1;
        e2[0]    = -32'sd20;
        model();
        run_op(-1, -1, -1, 1'b0);
        check_outputs("neg");

        // Starts during MAC and coincident with done are ignored; inputs scrambled
        rand_inputs();
        model();
        run_op(50, 97, -1, 1'b1);
        chk("restart done_cycle", done_cyc, 97);
        chk("restart done_count", done_cnt, 1);
        chk("restart busy_profile", busy_err, 0);
        check_outputs("restart");

        // Random operands
        for (int t = 0; t < 4; t++) begin
            rand_inputs();
            model();
            run_op(-1, -1, -1, 1'b1);
            chk($sformatf("rand%0d done_cycle", t), done_cyc, 97);
            check_outputs($sformatf("rand%0d", t));
        end

        // Reset mid-operation aborts without a done pulse
        rand_inputs();
        run_op(-1, -1, 40, 1'b1);
        model_zero();
        chk("abort done_count", done_cnt, 0);
        chk("abort busy_profile", busy_err, 0);
        check_outputs("abort");

        // Recovery after abort
        rand_inputs();
        model();
        run_op(-1, -1, -1, 1'b0);
        chk("recover done_cycle", done_cyc, 97);
        check_outputs("recover");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
